// File: rtl/dmem_responder_if.sv
// Hart data-memory port plus console TX stream, as seen by dmem_responder.
// master = hart/top side, slave = responder side.
interface dmem_responder_if;
    logic [31:0] dmem_addr;
    logic        dmem_ren;
    logic        dmem_wen;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_mask;
    logic [31:0] dmem_rdata;
    logic        cons_valid;
    logic [7:0]  cons_data;
    logic        cons_ready;
    logic        err;

    modport master (
        output dmem_addr,
        output dmem_ren,
        output dmem_wen,
        output dmem_wdata,
        output dmem_mask,
        input  dmem_rdata,
        input  cons_valid,
        input  cons_data,
        output cons_ready,
        input  err
    );

    modport slave (
        input  dmem_addr,
        input  dmem_ren,
        input  dmem_wen,
        input  dmem_wdata,
        input  dmem_mask,
        output dmem_rdata,
        output cons_valid,
        output cons_data,
        input  cons_ready,
        output err
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: byte-masked RAM, 64-bit timer, console TX FIFO.
// Define DMEM_PROTOCOL_CHECK_EN to build the registered o_err protocol checker.
module dmem_responder #(
    parameter logic [31:0] RAM_BASE   = 32'h0001_0000,
    parameter int          RAM_WORDS  = 4096,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic            i_clk,
    input  logic            i_rst,
    dmem_responder_if.slave bus
);
    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        REG_TIME_LO   = 2'd0,
        REG_TIME_HI   = 2'd1,
        REG_CONS_DATA = 2'd2,
        REG_CONS_STAT = 2'd3
    } mmio_reg_e;

    function automatic logic [31:0] merge_lanes(
        input logic [31:0] old,
        input logic [31:0] wd,
        input logic [3:0]  m
    );
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++) begin
            if (m[b]) begin
                res[8*b +: 8] = wd[8*b +: 8];
            end
        end
        return res;
    endfunction

    logic          ram_hit;
    logic          mmio_hit;
    mmio_reg_e     mmio_sel;
    logic [AW-1:0] ram_idx;

    assign ram_hit  = bus.dmem_addr[31:AW+2] == RAM_BASE[31:AW+2];
    assign mmio_hit = bus.dmem_addr[31:4] == MMIO_BASE[31:4];
    assign mmio_sel = mmio_reg_e'(bus.dmem_addr[3:2]);
    assign ram_idx  = bus.dmem_addr[AW+1:2];

    // Writes landing on a reset edge are dropped everywhere, RAM included.
    logic wr_live;
    logic ram_we;
    logic tlo_we;
    logic thi_we;
    logic push_req;
    logic ovf_clr_req;

    assign wr_live     = bus.dmem_wen & ~i_rst & (bus.dmem_mask != 4'b0);
    assign ram_we      = wr_live & ram_hit;
    assign tlo_we      = wr_live & mmio_hit & (mmio_sel == REG_TIME_LO);
    assign thi_we      = wr_live & mmio_hit & (mmio_sel == REG_TIME_HI);
    assign push_req    = wr_live & mmio_hit & (mmio_sel == REG_CONS_DATA)
                       & bus.dmem_mask[0];
    assign ovf_clr_req = wr_live & mmio_hit & (mmio_sel == REG_CONS_STAT)
                       & bus.dmem_mask[0] & bus.dmem_wdata[2];

    logic [31:0] ram [RAM_WORDS];

    always_ff @(posedge i_clk) begin
        for (int b = 0; b < 4; b++) begin
            if (ram_we && bus.dmem_mask[b]) begin
                ram[ram_idx][8*b +: 8] <= bus.dmem_wdata[8*b +: 8];
            end
        end
    end

    logic [63:0] timer;

    // A software write to either half freezes the count for that cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            timer <= '0;
        end else if (tlo_we) begin
            timer[31:0] <= merge_lanes(timer[31:0], bus.dmem_wdata,
                                       bus.dmem_mask);
        end else if (thi_we) begin
            timer[63:32] <= merge_lanes(timer[63:32], bus.dmem_wdata,
                                        bus.dmem_mask);
        end else begin
            timer <= timer + 64'd1;
        end
    end

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          ovf;
    logic          fifo_empty;
    logic          fifo_full;
    logic          pop;
    logic          push;
    logic          ovf_set;

    assign fifo_empty = count == '0;
    assign fifo_full  = count == CW'(FIFO_DEPTH);
    assign pop        = ~fifo_empty & bus.cons_ready;
    assign push       = push_req & (~fifo_full | pop);
    assign ovf_set    = push_req & fifo_full & ~pop;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (ovf_clr_req) begin
                ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= bus.dmem_wdata[7:0];
        end
    end

    assign bus.cons_valid = ~fifo_empty;
    assign bus.cons_data  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr];

    logic [31:0] stat;
    logic [31:0] mmio_rdata;
    logic [31:0] rdata;

    always_comb begin
        stat       = '0;
        stat[0]    = fifo_empty;
        stat[1]    = fifo_full;
        stat[2]    = ovf;
        stat[15:8] = 8'(count);
    end

    always_comb begin
        mmio_rdata = '0;
        unique case (mmio_sel)
            REG_TIME_LO:   mmio_rdata = timer[31:0];
            REG_TIME_HI:   mmio_rdata = timer[63:32];
            REG_CONS_DATA: mmio_rdata = '0;
            REG_CONS_STAT: mmio_rdata = stat;
        endcase
    end

    always_comb begin
        rdata = '0;
        if (bus.dmem_ren) begin
            unique case (1'b1)
                ram_hit:  rdata = ram[ram_idx];
                mmio_hit: rdata = mmio_rdata;
                default:  rdata = '0;
            endcase
        end
    end

    assign bus.dmem_rdata = rdata;

`ifdef DMEM_PROTOCOL_CHECK_EN
    logic mapped;
    logic any_acc;
    logic violation;
    logic err_q;

    assign mapped    = ram_hit | mmio_hit;
    assign any_acc   = bus.dmem_ren | bus.dmem_wen;
    assign violation = (bus.dmem_ren & bus.dmem_wen)
                     | (any_acc & (bus.dmem_addr[1:0] != 2'b00))
                     | (any_acc & ~mapped)
                     | (bus.dmem_wen & (bus.dmem_mask == 4'b0));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= violation;
        end
    end

    assign bus.err = err_q;
`else
    logic unused_addr_lsb;

    assign unused_addr_lsb = ^bus.dmem_addr[1:0];
    assign bus.err         = 1'b0;
`endif
endmodule
